// File: rtl/ps2_note_encoder_pkg.sv
// Shared constants for the PS/2 note encoder: set-2 scancodes, decoder states,
// note encodings and octave saturation helpers.
package note_enc_pkg;

    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_C      = 8'h1C;
    localparam logic [7:0] SC_CS     = 8'h1D;
    localparam logic [7:0] SC_D      = 8'h1B;
    localparam logic [7:0] SC_DS     = 8'h24;
    localparam logic [7:0] SC_E      = 8'h23;
    localparam logic [7:0] SC_F      = 8'h2B;
    localparam logic [7:0] SC_FS     = 8'h2C;
    localparam logic [7:0] SC_G      = 8'h34;
    localparam logic [7:0] SC_GS     = 8'h35;
    localparam logic [7:0] SC_A      = 8'h33;
    localparam logic [7:0] SC_AS     = 8'h3C;
    localparam logic [7:0] SC_B      = 8'h3B;
    localparam logic [7:0] SC_C_HI   = 8'h42;
    localparam logic [7:0] SC_OCT_DN = 8'h1A;
    localparam logic [7:0] SC_OCT_UP = 8'h22;

    localparam logic [3:0] NOTE_C  = 4'd0;
    localparam logic [3:0] NOTE_CS = 4'd1;
    localparam logic [3:0] NOTE_D  = 4'd2;
    localparam logic [3:0] NOTE_DS = 4'd3;
    localparam logic [3:0] NOTE_E  = 4'd4;
    localparam logic [3:0] NOTE_F  = 4'd5;
    localparam logic [3:0] NOTE_FS = 4'd6;
    localparam logic [3:0] NOTE_G  = 4'd7;
    localparam logic [3:0] NOTE_GS = 4'd8;
    localparam logic [3:0] NOTE_A  = 4'd9;
    localparam logic [3:0] NOTE_AS = 4'd10;
    localparam logic [3:0] NOTE_B  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // Compare before adding so a ceiling of 7 cannot wrap the 3-bit value.
    function automatic logic [2:0] oct_inc_sat(input logic [2:0] oct, input logic [2:0] max_oct);
        if (oct >= max_oct) begin
            return max_oct;
        end else begin
            return oct + 3'd1;
        end
    endfunction

    function automatic logic [2:0] oct_dec_sat(input logic [2:0] oct);
        if (oct == 3'd0) begin
            return 3'd0;
        end else begin
            return oct - 3'd1;
        end
    endfunction

endpackage

// File: rtl/ps2_note_encoder_if.sv
// Scancode input and note-entry output bundle of the PS/2 note encoder.
interface ps2_note_encoder_if;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       note_in;
    logic [3:0] note;
    logic [2:0] octave;
    logic       key_held;

    modport master (
        input  scan_valid, scan_code,
        output note_in, note, octave, key_held
    );

    modport slave (
        output scan_valid, scan_code,
        input  note_in, note, octave, key_held
    );
endinterface

// File: rtl/ps2_note_encoder_map.sv
// Combinational key classifier: maps a scancode to a pitch class and the octave it
// plays at; octave-key detection exists only when NOTE_ENC_OCT_KEYS_EN is defined.
module ps2_note_map
    import note_enc_pkg::*;
#(
    parameter int MAX_OCTAVE = 6
) (
    input  logic [7:0] scan_code,
    input  logic [2:0] cur_octave,
    output logic       is_note,
    output logic [3:0] note,
    output logic [2:0] octave_bump,
    output logic       is_oct_up,
    output logic       is_oct_dn
);

    // Note lookup; octave_bump carries the octave the key sounds at.
    always_comb begin
        is_note     = 1'b1;
        note        = NOTE_C;
        octave_bump = cur_octave;
        case (scan_code)
            SC_C:    note = NOTE_C;
            SC_CS:   note = NOTE_CS;
            SC_D:    note = NOTE_D;
            SC_DS:   note = NOTE_DS;
            SC_E:    note = NOTE_E;
            SC_F:    note = NOTE_F;
            SC_FS:   note = NOTE_FS;
            SC_G:    note = NOTE_G;
            SC_GS:   note = NOTE_GS;
            SC_A:    note = NOTE_A;
            SC_AS:   note = NOTE_AS;
            SC_B:    note = NOTE_B;
            SC_C_HI: begin
                note        = NOTE_C;
                octave_bump = oct_inc_sat(cur_octave, 3'(MAX_OCTAVE));
            end
            default: is_note = 1'b0;
        endcase
    end

`ifdef NOTE_ENC_OCT_KEYS_EN
    assign is_oct_up = (scan_code == SC_OCT_UP);
    assign is_oct_dn = (scan_code == SC_OCT_DN);
`else
    assign is_oct_up = 1'b0;
    assign is_oct_dn = 1'b0;
`endif

endmodule

// File: rtl/ps2_note_encoder.sv
// PS/2 set-2 scancode stream to note-entry events, with held-key tracking.
// Define NOTE_ENC_OCT_KEYS_EN to enable the 1A/22 octave down/up keys.
module ps2_note_encoder
    import note_enc_pkg::*;
#(
    parameter int DEFAULT_OCTAVE = 4,
    parameter int MAX_OCTAVE     = 6
) (
    input  logic               clk,
    input  logic               reset,
    ps2_note_encoder_if.master bus
);

    localparam logic [2:0] RST_OCT = 3'(DEFAULT_OCTAVE);

    dec_state_e state_q, state_d;
    logic       make_s, break_s;
    logic       map_is_note_s, map_oct_up_s, map_oct_dn_s, note_key_s;
    logic [3:0] map_note_s;
    logic [2:0] map_oct_s;
    logic [2:0] cur_oct_s;

    logic       note_in_q, note_in_d;
    logic [3:0] note_q, note_d;
    logic [2:0] octave_q, octave_d;
    logic       key_held_q, key_held_d;
    logic [7:0] cur_key_q, cur_key_d;

    ps2_note_map #(.MAX_OCTAVE(MAX_OCTAVE)) u_map (
        .scan_code   (bus.scan_code),
        .cur_octave  (cur_oct_s),
        .is_note     (map_is_note_s),
        .note        (map_note_s),
        .octave_bump (map_oct_s),
        .is_oct_up   (map_oct_up_s),
        .is_oct_dn   (map_oct_dn_s)
    );

    // Octave keys never count as note keys.
    assign note_key_s = map_is_note_s & ~map_oct_up_s & ~map_oct_dn_s;

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decoder next state: prefixes advance, every other byte returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.scan_code == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (bus.scan_code == SC_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (bus.scan_code == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Decoder outputs: which byte is a make or break to act on.
    always_comb begin
        make_s  = 1'b0;
        break_s = 1'b0;
        if (bus.scan_valid) begin
            case (state_q)
                ST_IDLE: make_s  = (bus.scan_code != SC_BRK) && (bus.scan_code != SC_EXT);
                ST_BRK:  break_s = 1'b1;
                default: begin
                    make_s  = 1'b0;
                    break_s = 1'b0;
                end
            endcase
        end else begin
            make_s  = 1'b0;
            break_s = 1'b0;
        end
    end

`ifdef NOTE_ENC_OCT_KEYS_EN
    logic [2:0] oct_q, oct_d;
    logic       up_down_q, up_down_d, dn_down_q, dn_down_d;

    // Octave register steps only on the first make of an octave key.
    always_comb begin
        oct_d     = oct_q;
        up_down_d = up_down_q;
        dn_down_d = dn_down_q;
        if (make_s && map_oct_up_s) begin
            up_down_d = 1'b1;
            if (!up_down_q) begin
                oct_d = oct_inc_sat(oct_q, 3'(MAX_OCTAVE));
            end else begin
                oct_d = oct_q;
            end
        end else if (make_s && map_oct_dn_s) begin
            dn_down_d = 1'b1;
            if (!dn_down_q) begin
                oct_d = oct_dec_sat(oct_q);
            end else begin
                oct_d = oct_q;
            end
        end else if (break_s && map_oct_up_s) begin
            up_down_d = 1'b0;
        end else if (break_s && map_oct_dn_s) begin
            dn_down_d = 1'b0;
        end else begin
            oct_d = oct_q;
        end
    end

    // Octave register and octave-key down flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            oct_q     <= RST_OCT;
            up_down_q <= 1'b0;
            dn_down_q <= 1'b0;
        end else begin
            oct_q     <= oct_d;
            up_down_q <= up_down_d;
            dn_down_q <= dn_down_d;
        end
    end

    assign cur_oct_s = oct_q;
`else
    assign cur_oct_s = RST_OCT;
`endif

    // Note events: a new key (or a re-press after release) triggers; typematic repeats do not.
    always_comb begin
        note_in_d  = 1'b0;
        note_d     = note_q;
        octave_d   = octave_q;
        key_held_d = key_held_q;
        cur_key_d  = cur_key_q;
        if (make_s && note_key_s && ((bus.scan_code != cur_key_q) || !key_held_q)) begin
            note_in_d  = 1'b1;
            note_d     = map_note_s;
            octave_d   = map_oct_s;
            cur_key_d  = bus.scan_code;
            key_held_d = 1'b1;
        end else if (break_s && note_key_s && (bus.scan_code == cur_key_q)) begin
            key_held_d = 1'b0;
        end else begin
            key_held_d = key_held_q;
        end
    end

    // Output and current-key registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            note_in_q  <= 1'b0;
            note_q     <= NOTE_C;
            octave_q   <= RST_OCT;
            key_held_q <= 1'b0;
            cur_key_q  <= 8'h00;
        end else begin
            note_in_q  <= note_in_d;
            note_q     <= note_d;
            octave_q   <= octave_d;
            key_held_q <= key_held_d;
            cur_key_q  <= cur_key_d;
        end
    end

    assign bus.note_in  = note_in_q;
    assign bus.note     = note_q;
    assign bus.octave   = octave_q;
    assign bus.key_held = key_held_q;

endmodule

// File: tb/tb_ps2_note_encoder.sv
// Randomized and directed bench for ps2_note_encoder against a sequence-level model.
// Honours NOTE_ENC_OCT_KEYS_EN the same way as the design.
module tb_ps2_note_encoder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   pulses = 0;

    ps2_note_encoder_if bus ();

    ps2_note_encoder #(.DEFAULT_OCTAVE(4), .MAX_OCTAVE(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: pending prefix bytes plus the musical state.
    logic [7:0] note_keys [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                   8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
    logic [7:0] seq [$];
    int m_oct, m_cur, m_note, m_octave, m_pulse;
    bit m_held, m_up_down, m_dn_down;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pitch_of(input logic [7:0] c);
        for (int i = 0; i < 12; i++) begin
            if (note_keys[i] == c) return i;
        end
        if (c == 8'h42) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        seq.delete();
        m_oct = 4; m_cur = -1; m_note = 0; m_octave = 4; m_pulse = 0;
        m_held = 1'b0; m_up_down = 1'b0; m_dn_down = 1'b0;
    endtask

    task automatic model_make(input logic [7:0] c);
        int p;
        p = pitch_of(c);
        if (p >= 0) begin
            if (int'(c) != m_cur || !m_held) begin
                m_pulse  = 1;
                m_note   = p;
                m_octave = (c == 8'h42) ? ((m_oct + 1 > 6) ? 6 : m_oct + 1) : m_oct;
                m_cur    = int'(c);
                m_held   = 1'b1;
            end
        end
`ifdef NOTE_ENC_OCT_KEYS_EN
        else if (c == 8'h22) begin
            if (!m_up_down && m_oct < 6) m_oct++;
            m_up_down = 1'b1;
        end else if (c == 8'h1A) begin
            if (!m_dn_down && m_oct > 0) m_oct--;
            m_dn_down = 1'b1;
        end
`endif
    endtask

    task automatic model_break(input logic [7:0] c);
        if (pitch_of(c) >= 0 && int'(c) == m_cur) m_held = 1'b0;
`ifdef NOTE_ENC_OCT_KEYS_EN
        if (c == 8'h22) m_up_down = 1'b0;
        if (c == 8'h1A) m_dn_down = 1'b0;
`endif
    endtask

    // Collect bytes until a complete make, break or extended sequence is present.
    task automatic model_step(input logic v, input logic [7:0] c);
        m_pulse = 0;
        if (v) begin
            seq.push_back(c);
            if (seq[0] == 8'hE0) begin
                if (!(seq.size() == 1 || (seq.size() == 2 && c == 8'hF0))) seq.delete();
            end else if (seq.size() == 1 && c == 8'hF0) begin
                // break prefix, wait for the key byte
            end else begin
                if (seq.size() == 1) model_make(c);
                else model_break(c);
                seq.delete();
            end
        end
    endtask

    task automatic step(input logic rst_v, input logic v, input logic [7:0] c);
        @(negedge clk);
        reset = rst_v;
        bus.scan_valid = v;
        bus.scan_code = c;
        @(posedge clk);
        #1;
        if (!rst_v) model_reset();
        else model_step(v, c);
        chk("note_in", int'(bus.note_in), m_pulse);
        chk("note", int'(bus.note), m_note);
        chk("octave", int'(bus.octave), m_octave);
        chk("key_held", int'(bus.key_held), int'(m_held));
        if (bus.note_in) pulses++;
    endtask

    task automatic send(input logic [7:0] c);
        step(1'b1, 1'b1, c);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        pulses = 0;
    endtask

    initial begin
        logic [7:0] b;
        bus.scan_valid = 1'b0;
        bus.scan_code = 8'h00;
        model_reset();

        do_reset();
        chk("rst_note_in", int'(bus.note_in), 0);
        chk("rst_note", int'(bus.note), 0);
        chk("rst_octave", int'(bus.octave), 4);
        chk("rst_key_held", int'(bus.key_held), 0);

        send(8'h1C);
        chk("t1_pulse", int'(bus.note_in), 1);
        chk("t1_note", int'(bus.note), 0);
        chk("t1_octave", int'(bus.octave), 4);
        chk("t1_held", int'(bus.key_held), 1);
        idle();
        chk("t1_one_cycle", int'(bus.note_in), 0);
        send(8'hF0); send(8'h1C);
        chk("t1_released", int'(bus.key_held), 0);
        chk("t1_note_kept", int'(bus.note), 0);

        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C);
        chk("t2_typematic", pulses, 1);
        send(8'h33);
        chk("t2_second", pulses, 2);
        chk("t2_note", int'(bus.note), 9);
        chk("t2_held", int'(bus.key_held), 1);
        send(8'hF0); send(8'h1C);
        chk("t2_other_break", int'(bus.key_held), 1);

`ifdef NOTE_ENC_OCT_KEYS_EN
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(8'h22); send(8'h22);
            if (i < 3) begin send(8'hF0); send(8'h22); end
        end
        send(8'h1B);
        chk("t3_note", int'(bus.note), 2);
        chk("t3_octave_sat", int'(bus.octave), 6);
        send(8'h42);
        chk("t3_hi_note", int'(bus.note), 0);
        chk("t3_hi_octave", int'(bus.octave), 6);

        do_reset();
        for (int i = 0; i < 5; i++) send(8'h1A);
        send(8'h23);
        chk("t4_first_make", int'(bus.octave), 3);
        send(8'hF0); send(8'h1A); send(8'h1A);
        send(8'hF0); send(8'h23); send(8'h23);
        chk("t4_second_dn", int'(bus.octave), 2);
`else
        do_reset();
        send(8'h22); send(8'h1D);
        chk("t6_octave", int'(bus.octave), 4);
        chk("t6_note", int'(bus.note), 1);
`endif

        do_reset();
        send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
        chk("t5_ext_pulses", pulses, 0);
        chk("t5_ext_held", int'(bus.key_held), 0);
        send(8'hF0);
        step(1'b0, 1'b0, 8'h00);
        send(8'h1C);
        chk("t5_after_reset", int'(bus.note_in), 1);

        // Random traffic, weighted so prefixes, breaks and repeats all occur.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = note_keys[$urandom_range(0, 11)];
                4:       b = 8'h42;
                5:       b = 8'hF0;
                6:       b = 8'hE0;
                7:       b = ($urandom_range(0, 1) == 0) ? 8'h1A : 8'h22;
                8:       b = 8'($urandom_range(0, 255));
                default: b = 8'h00;
            endcase
            if ($urandom_range(0, 199) == 0) step(1'b0, 1'b0, 8'h00);
            else if (b == 8'h00) idle();
            else send(b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
